// File: rtl/led_walk_decoder_pkg.sv
// Shared types for the walking-LED receive path: FSM states, fault codes,
// walk direction constants and the per-sample step classification.
package led_walk_pkg;

  // Decoder tracking state
  typedef enum logic [1:0] {
    ACQUIRE = 2'd0,
    TRACK   = 2'd1,
    FAULT   = 2'd2
  } state_t;

  // Fault reason, exactly as reported on err_code
  typedef enum logic [1:0] {
    ERR_NONE   = 2'd0,
    ERR_ONEHOT = 2'd1,
    ERR_ADJ    = 2'd2,
    ERR_STALL  = 2'd3
  } err_code_t;

  // Walk direction as reported on dir
  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

  // How a new sample relates to the currently tracked position
  typedef enum logic [2:0] {
    STEP_HOLD    = 3'd0,  // same LED as before
    STEP_UP      = 3'd1,  // neighbour toward MSB (modulo width)
    STEP_DOWN    = 3'd2,  // neighbour toward bit 0 (modulo width)
    STEP_JUMP    = 3'd3,  // legal pattern, but not adjacent
    STEP_ILLEGAL = 3'd4   // not exactly one LED lit
  } step_t;

endpackage

// File: rtl/led_walk_decoder_if.sv
// Bus bundle between a walking-LED source/observer and led_walk_decoder.
// master: drives samples and fault clear; slave: the decoder.
interface led_walk_decoder_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
);
  localparam int POS_W = $clog2(WIDTH);

  logic                 sample_en;
  logic [WIDTH-1:0]     led_in;
  logic                 clr_err;
  logic [POS_W-1:0]     pos;
  logic                 pos_valid;
  logic                 dir;
  logic                 dir_valid;
  logic                 wrap;
  logic                 dir_change;
  logic [CNT_W-1:0]     step_count;
  logic                 err;
  logic [1:0]           err_code;

  modport master (
    output sample_en, led_in, clr_err,
    input  pos, pos_valid, dir, dir_valid, wrap, dir_change,
           step_count, err, err_code
  );

  modport slave (
    input  sample_en, led_in, clr_err,
    output pos, pos_valid, dir, dir_valid, wrap, dir_change,
           step_count, err, err_code
  );

endinterface

// File: rtl/led_walk_decoder_onehot_enc.sv
// Combinational one-hot encoder: returns the index of the lit bit and
// whether exactly one bit is lit. idx is only meaningful when legal = 1.
module led_onehot_enc #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0]         onehot,
  output logic [$clog2(WIDTH)-1:0] idx,
  output logic                     legal
);

  localparam int IDX_W = $clog2(WIDTH);

  logic [IDX_W-1:0] masked_idx [WIDTH];

  // Each bit contributes its own index when set; for a legal pattern
  // exactly one term is non-zero so an OR-reduction yields the index.
  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_mask
    assign masked_idx[gi] = onehot[gi] ? IDX_W'(gi) : '0;
  end

  // OR-reduce the per-bit indices
  always_comb begin
    idx = '0;
    for (int i = 0; i < WIDTH; i++) begin
      idx = idx | masked_idx[i];
    end
  end

  // Exactly one bit set: non-zero and clearing the lowest set bit leaves zero
  assign legal = (|onehot) && ((onehot & (onehot - WIDTH'(1))) == '0);

endmodule

// File: rtl/led_walk_decoder.sv
// Walking-LED receive decoder. Samples a one-hot LED bus on sample_en and
// recovers position, walk direction, wrap/direction-change pulses and a
// saturating step count; any illegal pattern or step raises a sticky fault.
// Optional build macro LED_WALK_STALL_DETECT_EN adds a stall fault after
// STALL_LIMIT consecutive held samples while tracking.
module led_walk_decoder
  import led_walk_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int CNT_W       = 16,
  parameter int STALL_LIMIT = 4
) (
  input  logic             clkIn,
  input  logic             rst,
  led_walk_decoder_if.slave bus
);

  localparam int POS_W = $clog2(WIDTH);

  // Parameter sanity: power-of-two width of at least 4, positive stall limit
  if (WIDTH < 4 || (WIDTH & (WIDTH - 1)) != 0 || STALL_LIMIT < 1 || CNT_W < 1) begin : g_bad_param
    $error("led_walk_decoder: illegal parameter set");
  end

  state_t           state_reg;
  logic [POS_W-1:0] pos_reg;
  logic             pos_valid_reg;
  logic             dir_reg;
  logic             dir_valid_reg;
  logic             wrap_reg;
  logic             dir_change_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic             err_reg;
  err_code_t        err_code_reg;

`ifdef LED_WALK_STALL_DETECT_EN
  localparam int STALL_W = $clog2(STALL_LIMIT + 1);
  logic [STALL_W-1:0] stall_reg;
`endif

  logic [POS_W-1:0] enc_idx;
  logic             enc_legal;
  logic [POS_W-1:0] pos_up;
  logic [POS_W-1:0] pos_dn;
  step_t            step_kind;
  logic             wrap_hit;
  logic             fault_now;
  err_code_t        fault_code_now;

  led_onehot_enc #(
    .WIDTH (WIDTH)
  ) u_enc (
    .onehot (bus.led_in),
    .idx    (enc_idx),
    .legal  (enc_legal)
  );

  // Neighbour positions; POS_W-bit arithmetic wraps modulo WIDTH
  assign pos_up = pos_reg + POS_W'(1);
  assign pos_dn = pos_reg - POS_W'(1);

  // Classify the current sample against the tracked position
  always_comb begin
    step_kind = STEP_ILLEGAL;
    if (!enc_legal) begin
      step_kind = STEP_ILLEGAL;
    end else if (enc_idx == pos_reg) begin
      step_kind = STEP_HOLD;
    end else if (enc_idx == pos_dn) begin
      step_kind = STEP_DOWN;
    end else if (enc_idx == pos_up) begin
      step_kind = STEP_UP;
    end else begin
      step_kind = STEP_JUMP;
    end
  end

  // A wrap is the end-to-end step in either direction
  assign wrap_hit = ((step_kind == STEP_DOWN) && (pos_reg == '0)) ||
                    ((step_kind == STEP_UP)   && (pos_reg == '1));

  // Decide whether this sample faults, and why
  always_comb begin
    fault_now      = 1'b0;
    fault_code_now = ERR_NONE;
    if (state_reg == ACQUIRE) begin
      if (!enc_legal) begin
        fault_now      = 1'b1;
        fault_code_now = ERR_ONEHOT;
      end
    end else if (state_reg == TRACK) begin
      if (step_kind == STEP_ILLEGAL) begin
        fault_now      = 1'b1;
        fault_code_now = ERR_ONEHOT;
      end else if (step_kind == STEP_JUMP) begin
        fault_now      = 1'b1;
        fault_code_now = ERR_ADJ;
      end
`ifdef LED_WALK_STALL_DETECT_EN
      else if (step_kind == STEP_HOLD && (int'(stall_reg) + 1 >= STALL_LIMIT)) begin
        fault_now      = 1'b1;
        fault_code_now = ERR_STALL;
      end
`endif
    end
  end

  // Tracking FSM with registered outputs; clr_err outranks sample_en
  always_ff @(posedge clkIn) begin
    if (rst) begin
      state_reg      <= ACQUIRE;
      pos_reg        <= '0;
      pos_valid_reg  <= 1'b0;
      dir_reg        <= DIR_UP;
      dir_valid_reg  <= 1'b0;
      wrap_reg       <= 1'b0;
      dir_change_reg <= 1'b0;
      cnt_reg        <= '0;
      err_reg        <= 1'b0;
      err_code_reg   <= ERR_NONE;
`ifdef LED_WALK_STALL_DETECT_EN
      stall_reg      <= '0;
`endif
    end else begin
      wrap_reg       <= 1'b0;
      dir_change_reg <= 1'b0;
      if (bus.clr_err) begin
        state_reg     <= ACQUIRE;
        err_reg       <= 1'b0;
        err_code_reg  <= ERR_NONE;
        cnt_reg       <= '0;
        dir_valid_reg <= 1'b0;
        pos_valid_reg <= 1'b0;
`ifdef LED_WALK_STALL_DETECT_EN
        stall_reg     <= '0;
`endif
      end else if (bus.sample_en) begin
        case (state_reg)
          ACQUIRE, TRACK: begin
            if (fault_now) begin
              state_reg     <= FAULT;
              err_reg       <= 1'b1;
              err_code_reg  <= fault_code_now;
              pos_valid_reg <= 1'b0;
              dir_valid_reg <= 1'b0;
            end else if (state_reg == ACQUIRE) begin
              state_reg     <= TRACK;
              pos_reg       <= enc_idx;
              pos_valid_reg <= 1'b1;
`ifdef LED_WALK_STALL_DETECT_EN
              stall_reg     <= '0;
`endif
            end else if (step_kind == STEP_UP || step_kind == STEP_DOWN) begin
              pos_reg        <= enc_idx;
              dir_reg        <= (step_kind == STEP_DOWN) ? DIR_DOWN : DIR_UP;
              dir_valid_reg  <= 1'b1;
              wrap_reg       <= wrap_hit;
              dir_change_reg <= dir_valid_reg &&
                                (dir_reg != ((step_kind == STEP_DOWN) ? DIR_DOWN : DIR_UP));
              if (cnt_reg != '1) begin
                cnt_reg <= cnt_reg + CNT_W'(1);
              end
`ifdef LED_WALK_STALL_DETECT_EN
              stall_reg      <= '0;
`endif
            end else begin
`ifdef LED_WALK_STALL_DETECT_EN
              stall_reg <= stall_reg + STALL_W'(1);
`endif
            end
          end
          FAULT: begin
            // Samples are ignored until clr_err
          end
          default: begin
            state_reg <= ACQUIRE;
          end
        endcase
      end
    end
  end

  assign bus.pos        = pos_reg;
  assign bus.pos_valid  = pos_valid_reg;
  assign bus.dir        = dir_reg;
  assign bus.dir_valid  = dir_valid_reg;
  assign bus.wrap       = wrap_reg;
  assign bus.dir_change = dir_change_reg;
  assign bus.step_count = cnt_reg;
  assign bus.err        = err_reg;
  assign bus.err_code   = err_code_reg;

endmodule

// File: tb/tb_led_walk_decoder.sv
// Bench for led_walk_decoder: directed scenarios plus a random walk, with two
// decoders (16-bit and 7-bit step counters) checked every cycle against a
// rule-level model of the LED walk.
module tb_led_walk_decoder;

  localparam int WIDTH       = 8;
  localparam int CNT_W       = 16;
  localparam int CNT_S       = 7;
  localparam int STALL_LIMIT = 4;

  logic clkIn = 1'b0;
  logic rst   = 1'b1;
  always #5 clkIn = ~clkIn;

  led_walk_decoder_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();
  led_walk_decoder_if #(.WIDTH(WIDTH), .CNT_W(CNT_S)) bus_s ();

  assign bus_s.sample_en = bus.sample_en;
  assign bus_s.led_in    = bus.led_in;
  assign bus_s.clr_err   = bus.clr_err;

  led_walk_decoder #(.WIDTH(WIDTH), .CNT_W(CNT_W), .STALL_LIMIT(STALL_LIMIT)) dut (
    .clkIn (clkIn),
    .rst   (rst),
    .bus   (bus)
  );

  led_walk_decoder #(.WIDTH(WIDTH), .CNT_W(CNT_S), .STALL_LIMIT(STALL_LIMIT)) dut_s (
    .clkIn (clkIn),
    .rst   (rst),
    .bus   (bus_s)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit m_started = 0;
  bit m_locked, m_faulted, m_dir, m_dir_valid, m_wrap, m_dchg;
  int m_pos, m_count, m_code, m_holds;

  function automatic void m_fault(input int code);
    m_faulted   = 1;
    m_locked    = 0;
    m_dir_valid = 0;
    m_code      = code;
  endfunction

  function automatic void m_step(input int idx, input bit down);
    m_wrap      = (down && m_pos == 0) || (!down && m_pos == WIDTH - 1);
    m_dchg      = m_dir_valid && (m_dir != down);
    m_dir       = down;
    m_dir_valid = 1;
    m_pos       = idx;
    m_count     = m_count + 1;
    m_holds     = 0;
  endfunction

  always @(posedge clkIn) begin
    int idx;
    m_wrap = 0;
    m_dchg = 0;
    if (rst) begin
      m_started = 1; m_locked = 0; m_faulted = 0; m_dir = 0; m_dir_valid = 0;
      m_pos = 0; m_count = 0; m_code = 0; m_holds = 0;
    end else if (bus.clr_err) begin
      m_locked = 0; m_faulted = 0; m_dir_valid = 0; m_count = 0; m_code = 0; m_holds = 0;
    end else if (bus.sample_en && !m_faulted) begin
      idx = 0;
      for (int b = 0; b < WIDTH; b++) if (bus.led_in[b]) idx = b;
      if ($countones(bus.led_in) != 1) m_fault(1);
      else if (!m_locked) begin
        m_locked = 1; m_pos = idx; m_holds = 0;
      end else if (idx == m_pos) begin
        m_holds = m_holds + 1;
`ifdef LED_WALK_STALL_DETECT_EN
        if (m_holds >= STALL_LIMIT) m_fault(3);
`endif
      end else if (idx == (m_pos + WIDTH - 1) % WIDTH) m_step(idx, 1'b1);
      else if (idx == (m_pos + 1) % WIDTH) m_step(idx, 1'b0);
      else m_fault(2);
    end
  end

  // Compare every cycle, away from the active edge
  always @(negedge clkIn) begin
    if (m_started) begin
      check("pos",        32'(bus.pos),        32'(m_pos));
      check("pos_valid",  32'(bus.pos_valid),  32'(m_locked && !m_faulted));
      check("dir",        32'(bus.dir),        32'(m_dir));
      check("dir_valid",  32'(bus.dir_valid),  32'(m_dir_valid));
      check("wrap",       32'(bus.wrap),       32'(m_wrap));
      check("dir_change", 32'(bus.dir_change), 32'(m_dchg));
      check("step_count", 32'(bus.step_count), 32'((m_count > 65535) ? 65535 : m_count));
      check("err",        32'(bus.err),        32'(m_faulted));
      check("err_code",   32'(bus.err_code),   32'(m_code));
      check("s_step_count", 32'(bus_s.step_count), 32'((m_count > 127) ? 127 : m_count));
      check("s_pos",      32'(bus_s.pos),      32'(m_pos));
      check("s_err_code", 32'(bus_s.err_code), 32'(m_code));
    end
  end

  // ---------------- stimulus ----------------
  // Present one cycle of inputs, then return #1 after the edge that used them
  task automatic cyc(input logic se, input logic [WIDTH-1:0] v, input logic clr);
    bus.sample_en = se;
    bus.led_in    = v;
    bus.clr_err   = clr;
    @(posedge clkIn);
    #1;
    bus.sample_en = 1'b0;
    bus.clr_err   = 1'b0;
  endtask

  task automatic smp(input logic [WIDTH-1:0] v);
    cyc(1'b1, v, 1'b0);
  endtask

  initial begin
    logic [WIDTH-1:0] v;
    int r, d, idx;
    bus.sample_en = 0; bus.led_in = '0; bus.clr_err = 0;
    rst = 1;
    @(posedge clkIn); @(posedge clkIn); #1;
    check("lit_reset_pos_valid", 32'(bus.pos_valid), 0);
    check("lit_reset_step_count", 32'(bus.step_count), 0);
    rst = 0;

    // Basic up walk
    smp(8'h01); smp(8'h02); smp(8'h04);
    check("lit_walk_pos", 32'(bus.pos), 2);
    check("lit_walk_dir_valid", 32'(bus.dir_valid), 1);
    check("lit_walk_count", 32'(bus.step_count), 2);
    check("lit_walk_err", 32'(bus.err), 0);

    // Up wrap, then down wrap with direction reversal
    cyc(1'b0, '0, 1'b1);
    smp(8'h80); smp(8'h01);
    check("lit_upwrap_wrap", 32'(bus.wrap), 1);
    check("lit_upwrap_pos", 32'(bus.pos), 0);
    cyc(1'b0, '0, 1'b0);
    check("lit_wrap_once", 32'(bus.wrap), 0);
    smp(8'h01); smp(8'h80);
    check("lit_dnwrap_wrap", 32'(bus.wrap), 1);
    check("lit_dnwrap_dir", 32'(bus.dir), 1);
    check("lit_dnwrap_dchg", 32'(bus.dir_change), 1);

    // Non-adjacent step, then clr_err colliding with a sample
    cyc(1'b0, '0, 1'b1);
    smp(8'h04); smp(8'h10);
    check("lit_adj_code", 32'(bus.err_code), 2);
    check("lit_adj_pos_valid", 32'(bus.pos_valid), 0);
    cyc(1'b1, 8'h08, 1'b1);
    check("lit_clr_err", 32'(bus.err), 0);
    check("lit_clr_drop", 32'(bus.pos_valid), 0);
    smp(8'h08);
    check("lit_acq_pos", 32'(bus.pos), 3);

    // Illegal patterns
    cyc(1'b0, '0, 1'b1);
    smp(8'h00);
    check("lit_zero_code", 32'(bus.err_code), 1);
    cyc(1'b0, '0, 1'b1);
    smp(8'h03);
    check("lit_two_code", 32'(bus.err_code), 1);

    // Reset mid-walk
    cyc(1'b0, '0, 1'b1);
    v = 8'h01;
    for (int i = 0; i < 10; i++) begin smp(v); v = {v[WIDTH-2:0], v[WIDTH-1]}; end
    rst = 1; cyc(1'b0, '0, 1'b0); rst = 0;
    check("lit_rst_pos", 32'(bus.pos), 0);
    check("lit_rst_count", 32'(bus.step_count), 0);
    check("lit_rst_dir_valid", 32'(bus.dir_valid), 0);

    // Saturation: acquire plus 129 legal steps
    v = 8'h01;
    for (int i = 0; i < 130; i++) begin smp(v); v = {v[WIDTH-2:0], v[WIDTH-1]}; end
    check("lit_sat_small", 32'(bus_s.step_count), 127);
    check("lit_sat_wide", 32'(bus.step_count), 129);

    // Held samples
    cyc(1'b0, '0, 1'b1);
    smp(8'h04);
`ifdef LED_WALK_STALL_DETECT_EN
    for (int i = 0; i < 3; i++) smp(8'h04);
    check("lit_stall_before", 32'(bus.err), 0);
    smp(8'h04);
    check("lit_stall_code", 32'(bus.err_code), 3);
`else
    for (int i = 0; i < 20; i++) smp(8'h04);
    check("lit_hold_no_err", 32'(bus.err), 0);
    check("lit_hold_valid", 32'(bus.pos_valid), 1);
`endif

    // Random walk with sporadic faults, clears and resets
    cyc(1'b0, '0, 1'b1);
    for (int i = 0; i < 3000; i++) begin
      r = $urandom_range(0, 99);
      if (r < 1) begin
        rst = 1; cyc(1'b0, '0, 1'b0); rst = 0;
      end else if (r < 10) begin
        cyc(1'b0, WIDTH'($urandom), 1'b0);
      end else if (r < 14) begin
        cyc(1'(r & 1), WIDTH'($urandom), 1'b1);
      end else if (r < 18) begin
        smp(WIDTH'($urandom));
      end else if (r < 22) begin
        v = WIDTH'(1) << $urandom_range(0, WIDTH - 1);
        smp(v);
      end else begin
        d   = $urandom_range(0, 2);
        idx = (m_pos + WIDTH - 1 + d) % WIDTH;
        v   = WIDTH'(1) << idx;
        smp(v);
      end
      if (m_faulted && $urandom_range(0, 3) == 0) cyc(1'b0, '0, 1'b1);
    end

    cyc(1'b0, '0, 1'b0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/led_walk_decoder.md
Name: led_walk_decoder

Overview:
- Receive-side counterpart of the walking-LED generator: samples an 8-bit one-hot LED bus and recovers position, walk direction, wrap events and step count.
- Flags any illegal pattern or illegal step.
- Sits on the board-test/loopback path: generator output feeds led_in, and sample_en comes from the same divided-clock tick, synchronised into clkIn.

Parameters:
- WIDTH, 8, LED bus width; power of two, ≥ 4.
- CNT_W, 16, step counter width.
- STALL_LIMIT, 4, consecutive no-move samples before a stall fault (used only with the optional feature).

Ports:
- clkIn  in  1  system clock
- rst  in  1  synchronous, active-high reset
- sample_en  in  1  one-cycle strobe; led_in is valid this cycle
- led_in  in  WIDTH  observed LED pattern
- clr_err  in  1  clears fault; returns to ACQUIRE
- pos  out  $clog2(WIDTH)  index of the lit LED
- pos_valid  out  1  pos is trustworthy
- dir  out  1  1 = walking toward bit 0 (down), 0 = toward MSB (up)
- dir_valid  out  1  at least one legal step seen since acquire
- wrap  out  1  one-cycle pulse on an end-to-end wrap step
- dir_change  out  1  one-cycle pulse when a legal step reverses dir
- step_count  out  CNT_W  legal steps since acquire; saturates at all-ones
- err  out  1  sticky fault flag
- err_code  out  2  0 none, 1 not one-hot, 2 non-adjacent step, 3 stall

Behaviour:
- Interface: one clock domain, clkIn; reset is synchronous and active-high on rst.
- Reset values: all outputs 0; state ACQUIRE. A reset mid-operation discards the tracked position and counter immediately.
- Latency: every output is registered and updates on the clkIn edge after the sample_en cycle. Inputs are ignored when sample_en = 0; pulses are exactly one cycle.
- Decode: idx = position of the single set bit. Pattern is illegal if popcount(led_in) ≠ 1, including all-zero.
- States:
  - ACQUIRE:
    - legal sample → pos = idx, pos_valid = 1, go to TRACK.
    - illegal sample → FAULT, err_code = 1.
  - TRACK, with new idx compared to old pos:
    - equal → hold; no step, no count.
    - idx == pos-1 (mod WIDTH) → down step, dir = 1.
    - idx == pos+1 (mod WIDTH) → up step, dir = 0.
    - anything else → FAULT, err_code = 2.
    - illegal pattern → FAULT, err_code = 1.
  - FAULT: err = 1 and pos_valid = dir_valid = 0; err_code is held. Samples are ignored until clr_err.
- Legal step actions: pos = idx, step_count += 1 (saturating), dir_valid = 1.
  - wrap pulses for the down step 0 → WIDTH-1 and the up step WIDTH-1 → 0.
  - dir_change pulses only if dir_valid was already 1 and the new dir differs from the old one.
- WIDTH = 2 ambiguity is excluded by the WIDTH ≥ 4 rule.
- clr_err: in any state, goes to ACQUIRE and clears err, err_code, step_count, dir_valid and pos_valid. If it coincides with sample_en, clr_err wins and that sample is dropped.
- rst has priority over everything.

Optional Feature:
- Macro: LED_WALK_STALL_DETECT_EN.
- Defined: in TRACK, a stall counter increments on each held sample and resets on any legal step. When it reaches STALL_LIMIT → FAULT, err_code = 3.
- Undefined: held samples are tolerated indefinitely, err_code 3 is never produced, and STALL_LIMIT is unused.

Decomposition:
- Package led_walk_pkg:
  - state enum {ACQUIRE, TRACK, FAULT}
  - err_code enum {ERR_NONE, ERR_ONEHOT, ERR_ADJ, ERR_STALL}
  - direction constants DIR_UP = 0, DIR_DOWN = 1
- Sub-module led_onehot_enc: combinational WIDTH → {idx, legal}, reused by future LED checkers.
- Main module: FSM, step classification, counters.

Test Plan:
- Reset, then samples 01, 02, 04 → pos 0, 1, 2; dir 0; dir_valid = 1; step_count 2; err 0.
- Samples 80, 01 → wrap pulses once, pos 0, dir 0. Then 01, 80 → wrap pulses, dir 1, dir_change pulses.
- In TRACK at pos 2, sample 10 → err = 1, err_code 2, pos_valid 0. Then clr_err + sample_en in the same cycle → ACQUIRE, sample dropped; next 08 → pos 3.
- Sample 00 in ACQUIRE → err_code 1. Sample 03 after clr_err → err_code 1.
- Walk 10 steps, assert rst mid-walk → all outputs 0 on the next edge. 129 legal steps with CNT_W = 7 → step_count saturates at 127.
- With LED_WALK_STALL_DETECT_EN and STALL_LIMIT 4: 04 then four more 04 → err_code 3 after the 4th hold. Without the macro: no error after 20 holds.
